// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int unsigned BOOTH_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: add/sub on {Q[0],q_1}, then arithmetic
// right shift of {A,Q,q_1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = BOOTH_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      BOOTH_ADD: sum = a + m;
      BOOTH_SUB: sum = a - m;
      default:   sum = a;
    endcase
    // Shift replicates the post-add MSB of A into the vacated top bit.
    a_next   = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth.sv
// Sequential radix-2 Booth multiplier; each operation starts on reset release
// and the product stays valid until the next reset.
module booth
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = BOOTH_WIDTH
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               sign_a,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [WIDTH:0]   m;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             q_1_next;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .a_next   (a_next),
    .q_next   (q_next),
    .q_1_next (q_1_next)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      m         <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          m     <= {sign_a, in_a};
          q     <= in_b;
          a     <= '0;
          q_1   <= 1'b0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          a   <= a_next;
          q   <= q_next;
          q_1 <= q_1_next;
          cnt <= cnt + 1'b1;
          // cnt holds the index of the step being taken, so WIDTH-1 is the last.
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          out       <= {a[WIDTH-1:0], q};
          out_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth.sv
// Directed self-checking bench for the 32-bit Booth multiplier.
module tb_booth;

  localparam int unsigned W = 32;

  logic            CLK = 1'b0;
  logic            reset = 1'b1;
  logic [W-1:0]    in_a = '0;
  logic [W-1:0]    in_b = '0;
  logic            sign_a = 1'b0;
  logic [2*W-1:0]  out;
  logic            out_valid;

  int vectors = 0;
  int miscompares = 0;
  int edges;

  booth #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_a      (in_a),
    .in_b      (in_b),
    .sign_a    (sign_a),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts rising edges after reset release until out_valid; 0 means timeout.
  // If perturb_at is nonzero, operands are scrambled after that edge.
  task automatic wait_valid(input int perturb_at, output int n_edges);
    n_edges = 0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge CLK);
      #1;
      if (n == perturb_at) begin
        in_a   = 32'h1234_5678;
        in_b   = 32'hDEAD_BEEF;
        sign_a = 1'b1;
      end
      if (out_valid) begin
        n_edges = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic sa,
                        input logic [W-1:0] b, input logic [63:0] exp);
    @(negedge CLK);
    reset = 1'b1;
    in_a = a; in_b = b; sign_a = sa;
    @(negedge CLK);
    check({tag, "_rst_valid"}, {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    wait_valid(0, edges);
    check({tag, "_edges"}, 64'(edges), 64'd35);
    check(tag, out, exp);
  endtask

  initial begin
    #2;
    check("reset_out", out, 64'd0);
    check("reset_valid", {63'd0, out_valid}, 64'd0);

    run_op("p30_p90", 32'd30, 1'b0, 32'd90, 64'd2700);
    // Sticky output with inputs wandering after completion.
    in_a = 32'hFFFF_0000; in_b = 32'h0000_FFFF; sign_a = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("sticky_out", out, 64'd2700);
    check("sticky_valid", {63'd0, out_valid}, 64'd1);

    run_op("p30_n90", 32'd30, 1'b0, -32'sd90, -64'sd2700);
    run_op("n30_p90", -32'sd30, 1'b1, 32'd90, -64'sd2700);
    run_op("n30_n90", -32'sd30, 1'b1, -32'sd90, 64'd2700);
    run_op("p90_z", 32'd90, 1'b0, 32'd0, 64'd0);
    run_op("n90_z", -32'sd90, 1'b1, 32'd0, 64'd0);
    run_op("z_p90", 32'd0, 1'b0, 32'd90, 64'd0);
    run_op("z_n90", 32'd0, 1'b0, -32'sd90, 64'd0);
    run_op("z_z", 32'd0, 1'b0, 32'd0, 64'd0);
    run_op("min_min", 32'h8000_0000, 1'b1, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("min_one", 32'h8000_0000, 1'b1, 32'd1, 64'hFFFF_FFFF_8000_0000);
    run_op("max_max", 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    run_op("unsigned_a", 32'hFFFF_FFFF, 1'b0, 32'd2, 64'h0000_0001_FFFF_FFFE);

    // Abort at edge 10, restart with new operands, scramble inputs during RUN.
    @(negedge CLK);
    reset = 1'b1;
    in_a = 32'd30; in_b = 32'd90; sign_a = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    reset = 1'b1;
    #1;
    check("abort_out", out, 64'd0);
    check("abort_valid", {63'd0, out_valid}, 64'd0);
    @(negedge CLK);
    in_a = 32'd7; in_b = -32'sd6; sign_a = 1'b0;
    @(negedge CLK);
    check("abort_hold_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    wait_valid(5, edges);
    check("restart_edges", 64'(edges), 64'd35);
    check("restart_out", out, -64'sd42);

    // Asynchronous reset while in DONE.
    @(negedge CLK);
    #2;
    reset = 1'b1;
    #1;
    check("done_rst_valid", {63'd0, out_valid}, 64'd0);
    check("done_rst_out", out, 64'd0);
    @(negedge CLK);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth.md
# booth

Sequential radix-2 Booth multiplier for two's-complement operands. It multiplies a WIDTH-bit multiplicand by a WIDTH-bit multiplier over WIDTH iteration cycles and presents a 2·WIDTH-bit product with a sticky valid flag. It is a standalone arithmetic block; each operation is started by pulsing reset.

## Interface
Parameters:
- WIDTH, 32: operand width. The product is 2·WIDTH bits wide.

Ports:
- CLK, in, 1: clock, rising edge.
- reset, in, 1: reset, asynchronous, active-high. Deassertion starts a new multiplication.
- in_a, in, WIDTH: multiplicand (M).
- in_b, in, WIDTH: multiplier (Q), two's complement.
- sign_a, in, 1: extension bit of the multiplicand. Drive it with in_a[WIDTH-1] for signed operation.
- out, out, 2·WIDTH: product, signed.
- out_valid, out, 1: product valid. It is sticky until the next reset.

## Operation
- Arithmetic: out = low 2·WIDTH bits of {sign_a,in_a} × signed(in_b). The multiplicand is held as a WIDTH+1-bit signed value.
  - When sign_a = in_a[WIDTH-1], this is the exact signed product. No overflow is possible.
- Registers:
  - A: accumulator, WIDTH+1 bits.
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - M: WIDTH+1 bits.
  - cnt: counter, clog2(WIDTH)+1 bits.
  - state.
- States and transitions:
  - IDLE: entered on reset.
  - LOAD:
    - Load M = {sign_a,in_a}, Q = in_b, A = 0, q_1 = 0, cnt = 0.
    - Go to RUN.
  - RUN, one Booth step per cycle:
    - Add or subtract on {Q[0],q_1}: 01 gives A+M, 10 gives A−M, 00 or 11 gives no change. Use WIDTH+1-bit wrap arithmetic.
    - Then arithmetic right shift of {A,Q,q_1} by one, replicating A's MSB.
    - Increment cnt. When cnt reaches WIDTH−1 on this step, go to DONE.
  - DONE:
    - out = {A,Q}[2·WIDTH-1:0]. out_valid = 1.
    - Hold all registers. Stay in DONE until the next reset.
- Operands are sampled only in LOAD. Later changes on in_a, in_b or sign_a are ignored until the next reset.
- Zero operands need no special-case path. The result is 0.

## Timing
- While reset is high: state = IDLE, out = 0, out_valid = 0, A/Q/q_1/cnt = 0.
- Edge 1 after reset falls: IDLE→LOAD. Edge 2: operands captured.
- Edges 3…WIDTH+2: the WIDTH Booth steps.
- Edge WIDTH+3: DONE. out and out_valid update together on this edge, 35 edges for WIDTH=32.
  - out_valid never rises while out is stale.
- out and out_valid are registered, with no combinational path from the inputs.
- Reset asserted mid-operation: the operation aborts immediately (asynchronously). out returns to 0 and out_valid to 0.
- Reset asserted in DONE: out_valid clears immediately.

## Structure
- Shared package booth_pkg:
  - default WIDTH = 32.
  - state enum {IDLE, LOAD, RUN, DONE}.
  - BOOTH_ADD = 2'b01, BOOTH_SUB = 2'b10.
- One natural sub-module, booth_step. It is combinational:
  - Inputs: A, Q, q_1, M.
  - Outputs: next {A,Q,q_1}, i.e. add/sub followed by the arithmetic shift.
- The top level holds the registers, counter and FSM. Expected size is about 150–250 lines of RTL.

## Test plan
- 30 × 90 → out = 2700, with out_valid rising exactly at edge 35 after reset falls.
- 30 × −90 → −2700. −30 × 90 → −2700. −30 × −90 → 2700.
- 90 × 0, −90 × 0, 0 × 90, 0 × −90, 0 × 0 → out = 0 and out_valid = 1.
- Corner values:
  - −2^31 × −2^31 → 2^62.
  - −2^31 × 1 → −2^31 (sign-extended to 64 bits).
  - (2^31−1) × (2^31−1) → 0x3FFFFFFF00000001.
- sign_a = 0 with in_a = 0xFFFFFFFF, in_b = 2 → 0x1FFFFFFFE (unsigned multiplicand).
- Reset pulsed at edge 10 of an operation with new operands → out = 0 and out_valid = 0 during reset, then the new product is valid 35 edges after release. Changing in_a/in_b during RUN does not alter the result.
